// File: rtl/sha2_stream_ctrl.sv
// Sequences one 16-word message load into the SHA-2 accelerator and streams
// the digest back out. Latency: accept -> first digest word is
// RST_CYCLES + 1 + N_WORDS + core latency + 2 cycles when the message never stalls.
// Backpressure: the message stream stalls via o_msg_ready, and the digest stream
// holds o_dig_data/o_dig_valid until i_dig_ready.
//
// Ports:
//   i_clk, i_rst                   clock, asynchronous active-high reset
//   i_cmd_*, o_cmd_ready           per-message command (mode, length in bits)
//   i_msg_*, o_msg_ready           64-bit message word stream
//   o_dig_*, i_dig_ready           digest word stream, MS word first, last flag
//   o_busy, o_error                activity, sticky core-timeout flag
//   o_sha_*, i_sha_*               accelerator control/address/data interface
module sha2_stream_ctrl #(
  parameter int N_WORDS    = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_mode,
  input  logic [63:0] i_cmd_length,
  input  logic        i_msg_valid,
  output logic        o_msg_ready,
  input  logic [63:0] i_msg_data,
  output logic        o_dig_valid,
  input  logic        i_dig_ready,
  output logic [63:0] o_dig_data,
  output logic        o_dig_last,
  output logic        o_busy,
  output logic        o_error,
  output logic [7:0]  o_sha_control,
  output logic [4:0]  o_sha_add,
  output logic [63:0] o_sha_data,
  input  logic [63:0] i_sha_data_out,
  input  logic        i_sha_end_op
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_RST   = 2'b00;
  localparam logic [1:0] OP_LEN   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_START = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_LEN,
    S_LOAD,
    S_START,
    S_READ,
    S_OUT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]     mode_q;
  logic [63:0]    len_q;
  logic [RCW-1:0] rst_cnt;
  logic [4:0]     word_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [2:0]     dig_idx;
  logic [2:0]     dig_max;
  logic           rd_wait;
  logic           last_word;

  logic cmd_fire, msg_fire, dig_fire, timeout_hit;

  // Index of the final digest word for the latched mode.
  always_comb begin
    dig_max = 3'd7;
    case (mode_q)
      2'b00:   dig_max = 3'd7;
      2'b01:   dig_max = 3'd5;
      2'b10:   dig_max = 3'd7;
      2'b11:   dig_max = 3'd3;
      default: dig_max = 3'd7;
    endcase
  end

  assign last_word   = (dig_idx == dig_max);
  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_msg_ready = (state_q == S_LOAD);
  assign o_busy      = (state_q != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_fire    = 1'b0;
    msg_fire    = 1'b0;
    dig_fire    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          cmd_fire = 1'b1;
          state_d  = S_CRST;
        end
      end
      S_CRST: begin
        if (rst_cnt == RCW'(RST_CYCLES - 1)) state_d = S_LEN;
      end
      S_LEN: state_d = S_LOAD;
      S_LOAD: begin
        if (i_msg_valid) begin
          msg_fire = 1'b1;
          if (word_cnt == 5'(N_WORDS - 1)) state_d = S_START;
        end
      end
      S_START: begin
        if (i_sha_end_op) begin
          state_d = S_READ;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_wait) state_d = S_OUT;
      end
      S_OUT: begin
        if (i_dig_ready) begin
          dig_fire = 1'b1;
          state_d  = last_word ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q        <= 2'b00;
      len_q         <= '0;
      rst_cnt       <= '0;
      word_cnt      <= '0;
      tmo_cnt       <= '0;
      dig_idx       <= '0;
      rd_wait       <= 1'b0;
      o_error       <= 1'b0;
      o_dig_valid   <= 1'b0;
      o_dig_data    <= '0;
      o_dig_last    <= 1'b0;
      o_sha_control <= 8'h00;
      o_sha_add     <= '0;
      o_sha_data    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            mode_q        <= i_cmd_mode;
            len_q         <= i_cmd_length;
            o_error       <= 1'b0;
            rst_cnt       <= '0;
            o_sha_control <= {4'h0, i_cmd_mode, OP_RST};
          end
        end
        S_CRST: begin
          rst_cnt <= rst_cnt + 1'b1;
          if (state_d == S_LEN) begin
            o_sha_control[1:0] <= OP_LEN;
            o_sha_add          <= '0;
            o_sha_data         <= len_q;
          end
        end
        S_LEN: begin
          o_sha_control[1:0] <= OP_LOAD;
          word_cnt           <= '0;
          tmo_cnt            <= '0;
        end
        S_LOAD: begin
          // The word goes out on the registered bus the cycle after it is
          // accepted; add/data otherwise hold their last value.
          if (msg_fire) begin
            o_sha_add  <= word_cnt;
            o_sha_data <= i_msg_data;
            word_cnt   <= word_cnt + 1'b1;
          end
        end
        S_START: begin
          // op only turns to START here, so the final word keeps op=LOAD for
          // the first START cycle and the core still writes it.
          o_sha_control[1:0] <= OP_START;
          tmo_cnt            <= tmo_cnt + 1'b1;
          if (state_d == S_READ) begin
            dig_idx   <= '0;
            o_sha_add <= '0;
            rd_wait   <= 1'b0;
          end else if (timeout_hit) begin
            o_error            <= 1'b1;
            o_sha_control[1:0] <= OP_RST;
          end
        end
        S_READ: begin
          // First cycle presents the address, second sees the core's
          // registered read data.
          rd_wait <= ~rd_wait;
          if (rd_wait) begin
            o_dig_data  <= i_sha_data_out;
            o_dig_valid <= 1'b1;
            o_dig_last  <= last_word;
          end
        end
        S_OUT: begin
          if (dig_fire) begin
            o_dig_valid <= 1'b0;
            o_dig_last  <= 1'b0;
            if (last_word) begin
              o_sha_control[1:0] <= OP_RST;
            end else begin
              dig_idx   <= dig_idx + 1'b1;
              o_sha_add <= {2'b00, dig_idx + 3'd1};
            end
          end
        end
        S_DONE: begin
          // op already back at reset code; nothing else to update.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_stream_ctrl.sv
module tb_sha2_stream_ctrl;

  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [63:0] cmd_length;
  logic        msg_valid;
  logic        msg_ready;
  logic [63:0] msg_data;
  logic        dig_valid;
  logic        dig_ready;
  logic [63:0] dig_data;
  logic        dig_last;
  logic        busy;
  logic        error;
  logic [7:0]  sha_control;
  logic [4:0]  sha_add;
  logic [63:0] sha_data;
  logic [63:0] sha_data_out;
  logic        sha_end_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha2_stream_ctrl #(.N_WORDS(16), .RST_CYCLES(2), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_mode(cmd_mode), .i_cmd_length(cmd_length),
    .i_msg_valid(msg_valid), .o_msg_ready(msg_ready), .i_msg_data(msg_data),
    .o_dig_valid(dig_valid), .i_dig_ready(dig_ready),
    .o_dig_data(dig_data), .o_dig_last(dig_last),
    .o_busy(busy), .o_error(error),
    .o_sha_control(sha_control), .o_sha_add(sha_add), .o_sha_data(sha_data),
    .i_sha_data_out(sha_data_out), .i_sha_end_op(sha_end_op)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (spec-level) ----------------
  function automatic int dcount(input logic [1:0] mode);
    case (mode)
      2'b00: return 8;
      2'b01: return 6;
      2'b10: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] abc_word(input logic [1:0] mode, input int idx);
    case ({mode, 3'(idx)})
      5'b00_000: return 64'h00000000ba7816bf;
      5'b00_001: return 64'h000000008f01cfea;
      5'b00_010: return 64'h00000000414140de;
      5'b00_011: return 64'h000000005dae2223;
      5'b00_100: return 64'h00000000b00361a3;
      5'b00_101: return 64'h0000000096177a9c;
      5'b00_110: return 64'h00000000b410ff61;
      5'b00_111: return 64'h00000000f20015ad;
      5'b01_000: return 64'hcb00753f45a35e8b;
      5'b01_001: return 64'hb5a03d699ac65007;
      5'b01_010: return 64'h272c32ab0eded163;
      5'b01_011: return 64'h1a8b605a43ff5bed;
      5'b01_100: return 64'h8086072ba1e7cc23;
      5'b01_101: return 64'h58baeca134c825a7;
      5'b10_000: return 64'hddaf35a193617aba;
      5'b10_001: return 64'hcc417349ae204131;
      5'b10_010: return 64'h12e6fa4e89a97ea2;
      5'b10_011: return 64'h0a9eeee64b55d39a;
      5'b10_100: return 64'h2192992a274fc1a8;
      5'b10_101: return 64'h36ba3c23a3feebbd;
      5'b10_110: return 64'h454d4423643ce80e;
      5'b10_111: return 64'h2a9ac94fa54ca49f;
      5'b11_000: return 64'h53048e2681941ef9;
      5'b11_001: return 64'h9b2e29b76b4c7dab;
      5'b11_010: return 64'he4c2d0c634fc6d46;
      5'b11_011: return 64'he0e2f13107e7af23;
      default:   return 64'h0;
    endcase
  endfunction

  // Digest word idx of a message: real SHA-2 values for "abc", otherwise a
  // deterministic mix standing in for the hash. SHA-256 sees only bits 31:0.
  function automatic logic [63:0] digest_word(input logic [1:0] mode, input logic [63:0] len,
                                              input logic [63:0] m [16], input int idx);
    logic [63:0] h, w;
    bit is_abc;
    is_abc = (len == 64'd24);
    for (int j = 0; j < 16; j++) begin
      w = (mode == 2'b00) ? {32'h0, m[j][31:0]} : m[j];
      if (j == 0) begin
        if (w != ((mode == 2'b00) ? 64'h61626380 : 64'h6162638000000000)) is_abc = 0;
      end else if (w != 64'h0) begin
        is_abc = 0;
      end
    end
    if (is_abc) return abc_word(mode, idx);
    h = len + 64'(mode) * 64'h1000000000000001;
    for (int j = 0; j < 16; j++) begin
      w = (mode == 2'b00) ? {32'h0, m[j][31:0]} : m[j];
      h = (h ^ w) * 64'h9E3779B97F4A7C15 + 64'(j);
    end
    h = (h ^ 64'(idx)) * 64'hC2B2AE3D27D4EB4F;
    h = h ^ (h >> 29);
    return (mode == 2'b00) ? {32'h0, h[31:0]} : h;
  endfunction

  // ---------------- accelerator model ----------------
  logic [63:0] core_mem [16];
  logic [63:0] core_len;
  bit          core_started;
  int          core_cnt;
  int          core_lat = 5;
  bit          never_end = 0;
  bit          spur = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sha_end_op   <= 1'b0;
      sha_data_out <= '0;
      core_started <= 0;
      core_cnt     <= 0;
    end else begin
      sha_end_op <= 1'b0;
      case (sha_control[1:0])
        2'b00: core_started <= 0;
        2'b01: core_len <= sha_data;
        2'b10: begin
          if (sha_add < 5'd16) core_mem[sha_add[3:0]] <= sha_data;
          if (spur && sha_add == 5'd3) sha_end_op <= 1'b1;  // stray end_op during load
        end
        default: begin
          if (!core_started) begin
            core_started <= 1;
            core_cnt     <= 0;
          end else begin
            core_cnt <= core_cnt + 1;
            if (!never_end && core_cnt == core_lat) sha_end_op <= 1'b1;
          end
        end
      endcase
      sha_data_out <= digest_word(sha_control[3:2], core_len, core_mem, int'(sha_add));
    end
  end

  // Distinct consecutive addresses presented with op=load.
  logic [4:0] addr_q[$];
  always @(posedge clk) begin
    if (!rst && sha_control[1:0] == 2'b10)
      if (addr_q.size() == 0 || addr_q[$] != sha_add) addr_q.push_back(sha_add);
  end

  // ---------------- transaction driver / checker ----------------
  // pat: 0 always valid, 1 toggle, 2 random. stall: cycles ready stays low per
  // digest word, negative for random ready.
  task automatic run_txn(input logic [1:0] mode, input logic [63:0] len,
                         input logic [63:0] words [16], input int pat,
                         input int stall, input bit expect_tmo);
    logic [63:0] got_q[$];
    bit          last_q[$];
    logic [63:0] held = '0;
    bit stalled = 0, done = 0, tog = 0;
    int widx = 0, cyc = 0, hold = 0, tmo_cnt = -1, extra = 0, nd;
    nd = dcount(mode);
    never_end = expect_tmo;
    core_lat  = $urandom_range(2, 30);
    addr_q.delete();

    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1; cmd_mode = mode; cmd_length = len;
    @(negedge clk);
    cmd_valid = 0; cmd_mode = 2'($urandom); cmd_length = {$urandom, $urandom};
    chk("err_clr", 64'(error), 64'd0);
    chk("busy_after_cmd", 64'(busy), 64'd1);

    while (!done && cyc < 3000) begin
      if (expect_tmo && error) begin
        done = 1;
        break;
      end
      if (stalled) begin
        chk("dig_vld_hold", 64'(dig_valid), 64'd1);
        chk("dig_dat_hold", dig_data, held);
      end
      // A competing command while busy must be ignored.
      cmd_valid = (pat == 2 && widx > 0 && widx < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (widx < 16) begin
        case (pat)
          0: msg_valid = 1;
          1: begin tog = !tog; msg_valid = tog; end
          default: msg_valid = 1'($urandom_range(0, 1));
        endcase
        msg_data = words[widx];
      end else begin
        msg_valid = 0;
        msg_data  = {$urandom, $urandom};
      end
      if (msg_valid && msg_ready) begin
        widx++;
        if (widx == 16) tmo_cnt = 0;
      end
      if (dig_valid) begin
        dig_ready = (stall < 0) ? 1'($urandom_range(0, 1)) : (hold >= stall);
        if (dig_ready) begin
          got_q.push_back(dig_data);
          last_q.push_back(dig_last);
          hold = 0; stalled = 0;
          if (!expect_tmo && got_q.size() == nd) done = 1;
        end else begin
          hold++; stalled = 1; held = dig_data;
        end
      end else begin
        dig_ready = 1'($urandom_range(0, 1));
        stalled = 0;
      end
      @(negedge clk);
      cyc++;
      if (tmo_cnt >= 0) tmo_cnt++;
    end
    cmd_valid = 0; msg_valid = 0;
    if (!done) chk("txn_budget", 64'd0, 64'd1);

    if (expect_tmo) begin
      // START lasts TIMEOUT cycles; error is visible the cycle after.
      chk("tmo_cycles", 64'(tmo_cnt), 64'(TIMEOUT + 1));
      chk("tmo_no_dig", 64'(got_q.size()), 64'd0);
    end else begin
      chk("dig_count", 64'(got_q.size()), 64'(nd));
      for (int i = 0; i < got_q.size() && i < nd; i++) begin
        chk($sformatf("dig_word%0d_m%0d", i, mode), got_q[i], digest_word(mode, len, words, i));
        chk($sformatf("dig_last%0d", i), 64'(last_q[i]), 64'(i == nd - 1));
      end
    end

    for (int k = 0; k < 20; k++) begin
      if (dig_valid) extra++;
      if (!busy) break;
      @(negedge clk);
    end
    chk("no_extra_dig", 64'(extra), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
    chk("ctl_after", 64'(sha_control), 64'({4'h0, mode, 2'b00}));
    chk("err_after", 64'(error), 64'(expect_tmo));
    chk("addr_count", 64'(addr_q.size()), 64'd16);
    for (int i = 0; i < addr_q.size() && i < 16; i++)
      chk($sformatf("addr%0d", i), 64'(addr_q[i]), 64'(i));
  endtask

  task automatic reset_mid_load();
    int hs = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_mode = 2'b10; cmd_length = 64'd24;
    @(negedge clk);
    cmd_valid = 0;
    for (int c = 0; c < 100 && hs < 5; c++) begin
      msg_valid = 1; msg_data = {$urandom, $urandom};
      if (msg_ready) hs++;
      @(negedge clk);
    end
    chk("rst_load_hs", 64'(hs), 64'd5);
    chk("rst_load_busy", 64'(busy), 64'd1);
    rst = 1;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_ctl", 64'(sha_control), 64'h00);
    chk("rst_dig_vld", 64'(dig_valid), 64'd0);
    @(posedge clk); #1;
    chk("rst_next_busy", 64'(busy), 64'd0);
    chk("rst_next_msg_rdy", 64'(msg_ready), 64'd0);
    @(negedge clk);
    rst = 0; msg_valid = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] w [16];
    logic [1:0]  m;
    rst = 1; cmd_valid = 0; cmd_mode = 0; cmd_length = 0;
    msg_valid = 0; msg_data = 0; dig_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ctl", 64'(sha_control), 64'h00);
    chk("reset_dig_vld", 64'(dig_valid), 64'd0);
    chk("reset_err", 64'(error), 64'd0);
    chk("reset_msg_rdy", 64'(msg_ready), 64'd0);
    chk("reset_add_data", {sha_data[58:0], sha_add}, 64'd0);
    rst = 0;

    // "abc" in each mode
    for (int k = 0; k < 16; k++) w[k] = 64'h0;
    w[0] = 64'h61626380;
    run_txn(2'b00, 64'd24, w, 0, 0, 0);
    w[0] = 64'h6162638000000000;
    run_txn(2'b10, 64'd24, w, 0, 0, 0);
    run_txn(2'b01, 64'd24, w, 0, 1, 0);
    run_txn(2'b11, 64'd24, w, 0, 0, 0);
    // toggling message valid, digest ready low 3 cycles per word
    w[0] = 64'h61626380;
    run_txn(2'b00, 64'd24, w, 1, 3, 0);

    reset_mid_load();

    // core never finishes, then a normal command recovers
    for (int k = 0; k < 16; k++) w[k] = {$urandom, $urandom};
    run_txn(2'b01, 64'd1000, w, 0, 0, 1);
    for (int k = 0; k < 16; k++) w[k] = 64'h0;
    w[0] = 64'h6162638000000000;
    run_txn(2'b10, 64'd24, w, 0, 0, 0);

    // random messages, modes, stalls and stray end_op pulses
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 16; k++) w[k] = {$urandom, $urandom};
      m    = 2'($urandom);
      spur = 1'($urandom_range(0, 1));
      run_txn(m, {32'h0, $urandom}, w, 2, -1, 0);
    end
    spur = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha2_stream_ctrl.md
Name: sha2_stream_ctrl

Overview:
- Sequencer placed directly upstream and downstream of the SHA-2 accelerator (sha2_xl control/address/data interface).
- Accepts a per-message command (mode, length) and a valid/ready stream of 64-bit message words. Drives the accelerator's control encoding, address and data buses, then waits for end-of-operation.
- Reads the digest words back and presents them as a valid/ready output stream with a last flag.
- Handles one 1024-bit load (16 words) per command. An error flag reports a core timeout.

Parameters:
- N_WORDS, 16, message words loaded per command (addresses 0..N_WORDS-1)
- RST_CYCLES, 2, cycles the accelerator control is held at reset code (XX00) before loading
- TIMEOUT, 1024, maximum cycles in START waiting for core end_op before error

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_mode  in  2  00 SHA-256, 01 SHA-384, 10 SHA-512, 11 SHA-512/256
- i_cmd_length  in  64  message length in bits, passed to core on LOAD_LENGTH
- i_msg_valid  in  1  message word valid
- o_msg_ready  out  1  message word accepted when valid&ready
- i_msg_data  in  64  message word (SHA-256: word in bits 31:0)
- o_dig_valid  out  1  digest word valid
- i_dig_ready  in  1  digest consumer ready
- o_dig_data  out  64  digest word, most significant word first
- o_dig_last  out  1  marks final digest word
- o_busy  out  1  high in any state except IDLE
- o_error  out  1  sticky timeout flag, cleared on next accepted command
- o_sha_control  out  8  accelerator control; [3:2]=mode, [1:0]=op (00 reset, 01 load_length, 10 load_data, 11 start), [7:4]=0
- o_sha_add  out  5  accelerator address
- o_sha_data  out  64  accelerator data input
- i_sha_data_out  in  64  accelerator output, registered one cycle after o_sha_add
- i_sha_end_op  in  1  accelerator end of operation

Behaviour:
- Reset (async, i_rst=1): state IDLE. All outputs are 0 except o_cmd_ready=1. o_sha_control=8'h00. o_error=0. Reset mid-operation aborts immediately; no digest is emitted.
- All sha outputs are registered. mode is latched at command accept and held on o_sha_control[3:2] until the next command.
- IDLE: o_sha_control[1:0]=00. On i_cmd_valid&o_cmd_ready, latch mode and length, clear o_error, go to CRST.
- CRST: op=00 for RST_CYCLES cycles, then go to LEN.
- LEN: one cycle with op=01, add=0, data=length. Go to LOAD with word counter=0.
- LOAD: op=10, o_msg_ready=1. On each handshake, drive add=counter and data=i_msg_data for that cycle, then increment the counter. Cycles without a handshake keep op=10, and add/data hold their last value. After the handshake with counter=N_WORDS-1, go to START. Extra words are not accepted because ready drops.
- START: op=11, held until readout ends. A cycle counter increments each cycle.
  - On i_sha_end_op=1: go to READ, with readout index=0.
  - If the cycle counter reaches TIMEOUT with no end_op: set o_error, set op=00, go to IDLE, emit no digest.
- READ: drive add=index (op stays 11). Wait 1 cycle for the registered core output, then capture i_sha_data_out into o_dig_data. Set o_dig_valid=1 and go to OUT.
- OUT: hold data and valid until i_dig_ready.
  - Digest word count D: 8 for SHA-256, 6 for SHA-384, 8 for SHA-512, 4 for SHA-512/256.
  - On handshake, if index=D-1: o_dig_last was 1 with this word; go to DONE.
  - Otherwise increment index and return to READ.
- DONE: op=00 for one cycle (puts core back to reset/idle), then go to IDLE.
- SHA-256 words are passed unmodified; the core already masks them to 32 bits.
- Simultaneous i_cmd_valid with busy: ignored, because ready=0.
- i_sha_end_op seen outside START: ignored.
- Minimum latency, command accept to first o_dig_valid with message stream always valid: RST_CYCLES + 1 + N_WORDS + core latency + 2 cycles.

Test Plan:
- Reset mid-LOAD (after 5 words) -> next cycle state IDLE, o_sha_control=00, o_cmd_ready=1, o_dig_valid=0.
- SHA-256 "abc": length=24, word0=0x61626380, rest 0 -> 8 digest words ba7816bf, 8f01cfea, 414140de, 5dae2223, b00361a3, 96177a9c, b410ff61, f20015ad; last on 8th.
- SHA-512 "abc": length=24, word0=0x6162638000000000 -> 8 words starting ddaf35a193617aba, last word a54ca49f; o_dig_last only on word 8.
- SHA-384 and SHA-512/256 "abc" -> exactly 6 and 4 words respectively (first words cb00753f45a35e8b and 53048e2681941ef9); no 7th/5th valid.
- Message stream with i_msg_valid toggling every other cycle, and i_dig_ready low for 3 cycles per word -> same digest; o_sha_add sequence 0..15 with no skipped or repeated address; o_dig_data stable while stalled.
- Core model that never asserts end_op, TIMEOUT=1024 -> o_error=1 at cycle 1024 of START, return to IDLE, no digest. The next command clears o_error and completes normally.
